// File: rtl/decode_stage_sb.sv
// RV32I decode stage: registered bundle, valid/ready handshakes, pending-write scoreboard.
// Optional: DECODE_ILLEGAL_TRAP_EN adds out_illegal and funct3/funct7 legality checks.
module decode_stage_sb #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PEND_WIDTH     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [XLEN-1:0]           in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [6:0]                out_op,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [REG_ADDR_WIDTH-1:0] out_rs1,
  output logic [REG_ADDR_WIDTH-1:0] out_rs2,
  output logic [2:0]                out_funct3,
  output logic [6:0]                out_funct7,
  output logic [XLEN-1:0]           out_imm,
  input  logic                      flush_i,
  input  logic                      wb_valid,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic                      out_illegal,
`endif
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd
);

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
  localparam logic [PEND_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_FENCE  = 7'h0f;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef struct packed {
    logic [XLEN-1:0]           pc;
    logic [6:0]                op;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [2:0]                f3;
    logic [6:0]                f7;
    logic [XLEN-1:0]           imm;
  } bundle_t;

  logic [6:0]                opc;
  logic [2:0]                f3;
  logic [6:0]                f7;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [31:0]               imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];
  assign rd  = REG_ADDR_WIDTH'(in_instr[11:7]);
  assign rs1 = REG_ADDR_WIDTH'(in_instr[19:15]);
  assign rs2 = REG_ADDR_WIDTH'(in_instr[24:20]);

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
  assign imm_u = {in_instr[31:12], 12'h000};

  logic        k_rd, k_rs1, k_rs2, k_f3, k_f7, known, bad_f, zap;
  logic [31:0] imm32;
  bundle_t     dec;

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_comb begin
    bad_f = 1'b0;
    case (opc)
      OP_LOAD:   bad_f = (f3 == 3'd3) | (f3[2:1] == 2'b11);
      OP_IMM:    bad_f = ((f3 == 3'd1) & (f7 != 7'h00)) |
                         ((f3 == 3'd5) & (f7 != 7'h00) & (f7 != 7'h20));
      OP_JALR:   bad_f = (f3 != 3'd0);
      OP_STORE:  bad_f = f3[2] | (f3 == 3'd3);
      OP_BRANCH: bad_f = (f3[2:1] == 2'b01);
      OP_OP:     bad_f = ~((f7 == 7'h00) |
                           ((f7 == 7'h20) & ((f3 == 3'd0) | (f3 == 3'd5))));
      default:   bad_f = 1'b0;
    endcase
  end
`else
  assign bad_f = 1'b0;
`endif

  always_comb begin
    k_rd  = 1'b0;
    k_rs1 = 1'b0;
    k_rs2 = 1'b0;
    k_f3  = 1'b0;
    k_f7  = 1'b0;
    known = 1'b1;
    imm32 = '0;
    case (opc)
      OP_LOAD, OP_IMM, OP_JALR: begin
        k_rd = 1'b1; k_rs1 = 1'b1; k_f3 = 1'b1; imm32 = imm_i;
      end
      OP_STORE: begin
        k_rs1 = 1'b1; k_rs2 = 1'b1; k_f3 = 1'b1; imm32 = imm_s;
      end
      OP_BRANCH: begin
        k_rs1 = 1'b1; k_rs2 = 1'b1; k_f3 = 1'b1; imm32 = imm_b;
      end
      OP_OP: begin
        k_rd = 1'b1; k_rs1 = 1'b1; k_rs2 = 1'b1;
        k_f3 = 1'b1; k_f7 = 1'b1;
      end
      OP_JAL: begin
        k_rd = 1'b1; imm32 = imm_j;
      end
      OP_LUI, OP_AUIPC: begin
        k_rd = 1'b1; imm32 = imm_u;
      end
      OP_FENCE, OP_SYSTEM: begin
        known = 1'b1;
      end
      default: known = 1'b0;
    endcase
    zap    = ~known | bad_f;
    dec    = '0;
    dec.pc = in_pc;
    if (!zap) begin
      dec.op  = opc;
      dec.rd  = k_rd  ? rd  : '0;
      dec.rs1 = k_rs1 ? rs1 : '0;
      dec.rs2 = k_rs2 ? rs2 : '0;
      dec.f3  = k_f3  ? f3  : '0;
      dec.f7  = k_f7  ? f7  : '0;
      dec.imm = XLEN'($signed(imm32));
    end
  end

  logic                  out_valid_q, out_valid_d;
  bundle_t               bundle_q, bundle_d;
  logic [PEND_WIDTH-1:0] cnt_q [NUM_REGS];
  logic [PEND_WIDTH-1:0] cnt_d [NUM_REGS];
  logic                  hz1, hz2, hz_full, hazard, accept, xfer;

  // Sources are already zeroed when unused, so a nonzero index means "used".
  assign hz1 = (dec.rs1 != '0) & ((cnt_q[dec.rs1] != '0) |
               (out_valid_q & (bundle_q.rd == dec.rs1)));
  assign hz2 = (dec.rs2 != '0) & ((cnt_q[dec.rs2] != '0) |
               (out_valid_q & (bundle_q.rd == dec.rs2)));
  assign hz_full = (dec.rd != '0) & (cnt_q[dec.rd] == CNT_MAX);
  assign hazard  = hz1 | hz2 | hz_full;

  assign in_ready = rst_n & ~flush_i & ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid_q & out_ready & ~flush_i;

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((i != 0) && xfer && (bundle_q.rd == REG_ADDR_WIDTH'(i)) &&
          !(wb_valid && (wb_rd == REG_ADDR_WIDTH'(i)))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if ((i != 0) && wb_valid &&
                   (wb_rd == REG_ADDR_WIDTH'(i)) &&
                   !(xfer && (bundle_q.rd == REG_ADDR_WIDTH'(i))) &&
                   (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic ill_q, ill_d;
  assign ill_d = accept ? zap : ill_q;
  always_ff @(posedge clk) begin
    if (!rst_n) ill_q <= 1'b0;
    else        ill_q <= ill_d;
  end
  assign out_illegal = ill_q;
`endif

  assign out_valid  = out_valid_q;
  assign out_pc     = bundle_q.pc;
  assign out_op     = bundle_q.op;
  assign out_rd     = bundle_q.rd;
  assign out_rs1    = bundle_q.rs1;
  assign out_rs2    = bundle_q.rs2;
  assign out_funct3 = bundle_q.f3;
  assign out_funct7 = bundle_q.f7;
  assign out_imm    = bundle_q.imm;

endmodule

// File: tb/tb_decode_stage_sb.sv
// Bench for decode_stage_sb: directed scenarios plus randomized traffic
// checked against a behavioural decode/scoreboard model.
module tb_decode_stage_sb;

  localparam int MAXP = 3;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic        flush_i, wb_valid;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_op, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2, wb_rd;
  logic [2:0]  out_funct3;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  decode_stage_sb dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op(out_op), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .flush_i(flush_i), .wb_valid(wb_valid),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .out_illegal(out_illegal),
`endif
    .wb_rd(wb_rd)
  );

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  bit   m_valid;
  dec_t m;
  int   pend [32];

  function automatic dec_t ref_dec(logic [31:0] w, logic [31:0] pc);
    dec_t d;
    bit   ur, us1, us2, uf3, uf7, legal;
    byte  form;
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    d = '{pc: pc, op: 0, rd: 0, rs1: 0, rs2: 0, f3: 0, f7: 0, imm: 0, ill: 0};
    {ur, us1, us2, uf3, uf7} = '0;
    form  = "N";
    legal = 1;
    case (w[6:0])
      7'h03: begin ur = 1; us1 = 1; uf3 = 1; form = "I"; legal = f3 inside {0, 1, 2, 4, 5}; end
      7'h13: begin
        ur = 1; us1 = 1; uf3 = 1; form = "I";
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) legal = f7 inside {7'h00, 7'h20};
      end
      7'h67: begin ur = 1; us1 = 1; uf3 = 1; form = "I"; legal = (f3 == 0); end
      7'h23: begin us1 = 1; us2 = 1; uf3 = 1; form = "S"; legal = f3 inside {0, 1, 2}; end
      7'h63: begin us1 = 1; us2 = 1; uf3 = 1; form = "B"; legal = !(f3 inside {2, 3}); end
      7'h33: begin
        {ur, us1, us2, uf3, uf7} = '1;
        legal = (f7 == 0) || (f7 == 7'h20 && f3 inside {0, 5});
      end
      7'h6f: begin ur = 1; form = "J"; end
      7'h37, 7'h17: begin ur = 1; form = "U"; end
      7'h0f, 7'h73: form = "N";
      default: begin d.ill = 1; return d; end
    endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (!legal) begin d.ill = 1; return d; end
`endif
    d.op  = w[6:0];
    d.rd  = ur  ? w[11:7]  : 5'd0;
    d.rs1 = us1 ? w[19:15] : 5'd0;
    d.rs2 = us2 ? w[24:20] : 5'd0;
    d.f3  = uf3 ? f3 : 3'd0;
    d.f7  = uf7 ? f7 : 7'd0;
    case (form)
      "I": d.imm = 32'(int'($signed(w[31:20])));
      "S": d.imm = 32'(int'($signed({w[31:25], w[11:7]})));
      "B": d.imm = 32'(int'($signed({w[31], w[7], w[30:25], w[11:8]})) * 2);
      "J": d.imm = 32'(int'($signed({w[31], w[19:12], w[20], w[30:21]})) * 2);
      "U": d.imm = {w[31:12], 12'h000};
      default: d.imm = 0;
    endcase
    return d;
  endfunction

  function automatic bit m_ready();
    dec_t d = ref_dec(in_instr, in_pc);
    bit   h = 0;
    if (d.rs1 != 0 && (pend[d.rs1] != 0 || (m_valid && m.rd == d.rs1))) h = 1;
    if (d.rs2 != 0 && (pend[d.rs2] != 0 || (m_valid && m.rd == d.rs2))) h = 1;
    if (d.rd != 0 && pend[d.rd] >= MAXP) h = 1;
    return rst_n && !flush_i && !h && (!m_valid || out_ready);
  endfunction

  task automatic tick();
    dec_t d  = ref_dec(in_instr, in_pc);
    bit   rs = rst_n;
    bit   ac = in_valid && m_ready();
    bit   xf = m_valid && out_ready && !flush_i;
    bit   fl = flush_i;
    int   tr = (xf && m.rd != 0) ? int'(m.rd) : -1;
    int   rt = (wb_valid && wb_rd != 0) ? int'(wb_rd) : -1;
    @(posedge clk);
    #1;
    if (!rs) begin
      m_valid = 0;
      m = '{pc: 0, op: 0, rd: 0, rs1: 0, rs2: 0, f3: 0, f7: 0, imm: 0, ill: 0};
      foreach (pend[i]) pend[i] = 0;
      return;
    end
    if (!(tr >= 0 && tr == rt)) begin
      if (tr >= 0) pend[tr]++;
      if (rt >= 0 && pend[rt] > 0) pend[rt]--;
    end
    if (fl) m_valid = 0;
    else if (ac) begin m_valid = 1; m = d; end
    else if (xf) m_valid = 0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; in_instr = 32'hFFF08293; in_pc = 32'h100;
    out_ready = 1; flush_i = 0; wb_valid = 0; wb_rd = 0;
    tick(); tick();
    settle();
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL reset_valid got %0b exp 0", out_valid);
    end
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++; $display("FAIL reset_in_ready got %0b exp 0", in_ready);
    end
    vecs++;
    if ({out_pc, out_op, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm} !== '0) begin
      errs++; $display("FAIL reset_fields pc=%h op=%h rd=%0d imm=%h exp all 0",
                       out_pc, out_op, out_rd, out_imm);
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    vecs++;
    if (out_illegal !== 1'b0) begin
      errs++; $display("FAIL reset_illegal got %0b exp 0", out_illegal);
    end
`endif
    in_valid = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_addi();
    in_valid = 1; in_instr = 32'hFFF08293; in_pc = 32'h100; out_ready = 1;
    settle();
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL addi_ready got %0b exp 1", in_ready);
    end
    tick();
    in_valid = 0;
    settle();
    vecs++;
    if ({out_valid, out_rd, out_rs1, out_rs2, out_imm} !== {1'b1, 5'd5, 5'd1, 5'd0, 32'hFFFFFFFF}) begin
      errs++; $display("FAIL addi_out got v=%0b rd=%0d rs1=%0d rs2=%0d imm=%h exp 1/5/1/0/ffffffff",
                       out_valid, out_rd, out_rs1, out_rs2, out_imm);
    end
    vecs++;
    if ({out_op, out_funct3, out_funct7, out_pc} !== {7'h13, 3'd0, 7'd0, 32'h100}) begin
      errs++; $display("FAIL addi_misc got op=%h f3=%0d f7=%h pc=%h exp 13/0/0/100",
                       out_op, out_funct3, out_funct7, out_pc);
    end
    tick();
    wb_valid = 1; wb_rd = 5;
    tick();
    wb_valid = 0;
  endtask

  task automatic test_raw();
    in_valid = 1; in_instr = 32'h00012183; in_pc = 32'h200; out_ready = 1;
    settle();
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL raw_lw_ready got %0b exp 1", in_ready);
    end
    tick();
    in_instr = 32'h00118233; in_pc = 32'h204;
    for (int c = 0; c < 3; c++) begin
      settle();
      vecs++;
      if (in_ready !== 1'b0) begin
        errs++; $display("FAIL raw_stall cyc=%0d got %0b exp 0", c, in_ready);
      end
      tick();
    end
    wb_valid = 1; wb_rd = 3;
    settle();
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++; $display("FAIL raw_retire_cycle got %0b exp 0", in_ready);
    end
    tick();
    wb_valid = 0;
    settle();
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL raw_unblock got %0b exp 1", in_ready);
    end
    tick();
    in_valid = 0;
    settle();
    vecs++;
    if ({out_valid, out_rd, out_rs1, out_rs2, out_funct3} !== {1'b1, 5'd4, 5'd3, 5'd1, 3'd0}) begin
      errs++; $display("FAIL raw_add_out got v=%0b rd=%0d rs1=%0d rs2=%0d exp 1/4/3/1",
                       out_valid, out_rd, out_rs1, out_rs2);
    end
    tick();
    wb_valid = 1; wb_rd = 4;
    tick();
    wb_valid = 0;
  endtask

  task automatic test_backpressure();
    in_valid = 1; in_instr = 32'h00612423; in_pc = 32'h300; out_ready = 0;
    tick();
    in_instr = 32'hFFF08293; in_pc = 32'h304;
    for (int c = 0; c < 3; c++) begin
      settle();
      vecs++;
      if ({out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2, out_funct3, out_imm} !==
          {1'b1, 32'h300, 7'h23, 5'd0, 5'd2, 5'd6, 3'd2, 32'd8}) begin
        errs++; $display("FAIL bp_hold cyc=%0d got v=%0b pc=%h rs1=%0d rs2=%0d imm=%h exp 1/300/2/6/8",
                         c, out_valid, out_pc, out_rs1, out_rs2, out_imm);
      end
      vecs++;
      if (in_ready !== 1'b0) begin
        errs++; $display("FAIL bp_in_ready cyc=%0d got %0b exp 0", c, in_ready);
      end
      tick();
    end
    in_valid = 0; out_ready = 1;
    settle();
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL bp_release_ready got %0b exp 1", in_ready);
    end
    tick();
    settle();
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL bp_drain got %0b exp 0", out_valid);
    end
    tick();
  endtask

  task automatic test_flush();
    in_valid = 1; in_instr = 32'h00500493; in_pc = 32'h400; out_ready = 0;
    tick();
    in_valid = 0; out_ready = 1; flush_i = 1;
    settle();
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++; $display("FAIL flush_in_ready got %0b exp 0", in_ready);
    end
    tick();
    flush_i = 0;
    in_instr = 32'h00948533;
    settle();
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL flush_valid got %0b exp 0", out_valid);
    end
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL flush_no_count got %0b exp 1", in_ready);
    end
    tick();
  endtask

  task automatic test_full();
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_instr = 32'h00100393; in_pc = 32'h500 + 32'(4 * k);
      tick();
      in_valid = 0;
      tick();
    end
    wb_valid = 1; wb_rd = 0;
    settle();
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++; $display("FAIL full_stall got %0b exp 0", in_ready);
    end
    tick();
    wb_rd = 8;
    settle();
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++; $display("FAIL full_wb0 got %0b exp 0", in_ready);
    end
    tick();
    wb_valid = 0;
    in_instr = 32'h000400B3;
    settle();
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL full_no_underflow got %0b exp 1", in_ready);
    end
    tick();
    in_instr = 32'h00100393;
    wb_valid = 1; wb_rd = 7;
    settle();
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++; $display("FAIL full_retire_cycle got %0b exp 0", in_ready);
    end
    tick();
    wb_valid = 0;
    settle();
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL full_unblock got %0b exp 1", in_ready);
    end
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1; wb_rd = 7;
      tick();
    end
    wb_valid = 0;
  endtask

  task automatic test_unknown();
    in_valid = 1; in_instr = 32'h0000007F; in_pc = 32'h600; out_ready = 1;
    tick();
    in_valid = 0;
    settle();
    vecs++;
    if ({out_valid, out_op, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm} !==
        {1'b1, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0}) begin
      errs++; $display("FAIL unknown_fields got v=%0b op=%h rd=%0d rs1=%0d imm=%h exp 1/0/0/0/0",
                       out_valid, out_op, out_rd, out_rs1, out_imm);
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    vecs++;
    if (out_illegal !== 1'b1) begin
      errs++; $display("FAIL unknown_illegal got %0b exp 1", out_illegal);
    end
`endif
    tick();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] w = $urandom;
    int          k = $urandom_range(0, 12);
    dec_t        d;
    int          held;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h33,
            7'h6f, 7'h37, 7'h17, 7'h7f, 7'h0f, 7'h73};
    if (k < 12) w[6:0] = ops[k];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    d = ref_dec(w, 0);
    held = (m_valid && m.rd == d.rd) ? 1 : 0;
    if (d.rd != 0 && pend[d.rd] + held >= MAXP) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      in_instr  = rand_instr();
      in_pc     = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush_i   = ($urandom_range(0, 15) == 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 8));
      settle();
      vecs++;
      if (in_ready !== m_ready()) begin
        errs++; $display("FAIL rand_in_ready cyc=%0d got %0b exp %0b instr=%h",
                         c, in_ready, m_ready(), in_instr);
      end
      vecs++;
      if (out_valid !== m_valid) begin
        errs++; $display("FAIL rand_out_valid cyc=%0d got %0b exp %0b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        vecs++;
        if ({out_pc, out_op, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm} !==
            {m.pc, m.op, m.rd, m.rs1, m.rs2, m.f3, m.f7, m.imm}) begin
          errs++; $display("FAIL rand_fields cyc=%0d got op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h exp op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h",
                           c, out_op, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
                           m.op, m.rd, m.rs1, m.rs2, m.f3, m.f7, m.imm);
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        vecs++;
        if (out_illegal !== m.ill) begin
          errs++; $display("FAIL rand_illegal cyc=%0d got %0b exp %0b", c, out_illegal, m.ill);
        end
`endif
      end
      tick();
    end
    in_valid = 0; flush_i = 0; wb_valid = 0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_raw();
    test_backpressure();
    test_flush();
    test_full();
    test_unknown();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
